// File: rtl/reg_file_nxw.sv
// Parametrised register file: one synchronous write port, two registered read ports.
// Optional hard-wired zero word and same-cycle write-to-read forwarding.
module reg_file_nxw #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WRITE,
  input  logic [AW-1:0]    ADDR_W,
  input  logic [WIDTH-1:0] DATA_W,
  input  logic             READ,
  input  logic [AW-1:0]    ADDR_R1,
  input  logic [AW-1:0]    ADDR_R2,
  output logic [WIDTH-1:0] DATA_R1,
  output logic [WIDTH-1:0] DATA_R2,
  output logic             R_VALID,
  output logic             ADDR_ERR
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam bit          ZR      = (ZERO_REG != 0);
  localparam bit          BP      = (BYPASS != 0);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             w_in, r1_in, r2_in;
  logic             wr_ok, err_nxt;
  logic [AW-1:0]    idx1, idx2;
  logic [WIDTH-1:0] sel1, sel2;

  assign w_in  = ({1'b0, ADDR_W}  < DEPTH_C);
  assign r1_in = ({1'b0, ADDR_R1} < DEPTH_C);
  assign r2_in = ({1'b0, ADDR_R2} < DEPTH_C);

  assign wr_ok   = WRITE && w_in && !(ZR && (ADDR_W == '0));
  assign err_nxt = (WRITE && !w_in) || (READ && (!r1_in || !r2_in));

  // Out-of-range addresses are steered to word 0 so the array is never indexed past DEPTH.
  assign idx1 = r1_in ? ADDR_R1 : '0;
  assign idx2 = r2_in ? ADDR_R2 : '0;

  function automatic logic [WIDTH-1:0] rd_sel(
    input logic             in_rng,
    input logic [AW-1:0]    a,
    input logic [WIDTH-1:0] word,
    input logic             wv,
    input logic [AW-1:0]    wa,
    input logic [WIDTH-1:0] wd
  );
    rd_sel = '0;
    if (!in_rng)
      rd_sel = '0;
    else if (ZR && (a == '0))
      rd_sel = '0;
    else if (BP && wv && (wa == a))
      rd_sel = wd;
    else
      rd_sel = word;
  endfunction

  assign sel1 = rd_sel(r1_in, ADDR_R1, mem[idx1], wr_ok, ADDR_W, DATA_W);
  assign sel2 = rd_sel(r2_in, ADDR_R2, mem[idx2], wr_ok, ADDR_W, DATA_W);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[ADDR_W] <= DATA_W;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DATA_R1  <= '0;
      DATA_R2  <= '0;
      R_VALID  <= 1'b0;
      ADDR_ERR <= 1'b0;
    end else begin
      if (READ) begin
        DATA_R1 <= sel1;
        DATA_R2 <= sel2;
      end
      R_VALID  <= READ;
      ADDR_ERR <= err_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_nxw.sv
// Directed bench for reg_file_nxw: three configurations driven from shared stimulus
// (defaults, no zero-reg/no bypass, 24-word depth).
module tb_reg_file_nxw;

  logic        CLK = 1'b0;
  logic        RST, WRITE, READ;
  logic [4:0]  ADDR_W, ADDR_R1, ADDR_R2;
  logic [31:0] DATA_W;

  logic [31:0] a_r1, a_r2, b_r1, b_r2, c_r1, c_r2;
  logic        a_rv, a_ae, b_rv, b_ae, c_rv, c_ae;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  reg_file_nxw u_a (
    .CLK(CLK), .RST(RST), .WRITE(WRITE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .READ(READ), .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
    .DATA_R1(a_r1), .DATA_R2(a_r2), .R_VALID(a_rv), .ADDR_ERR(a_ae)
  );

  reg_file_nxw #(.ZERO_REG(0), .BYPASS(0)) u_b (
    .CLK(CLK), .RST(RST), .WRITE(WRITE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .READ(READ), .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
    .DATA_R1(b_r1), .DATA_R2(b_r2), .R_VALID(b_rv), .ADDR_ERR(b_ae)
  );

  reg_file_nxw #(.DEPTH(24)) u_c (
    .CLK(CLK), .RST(RST), .WRITE(WRITE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .READ(READ), .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
    .DATA_R1(c_r1), .DATA_R2(c_r2), .R_VALID(c_rv), .ADDR_ERR(c_ae)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RST = 1'b0; WRITE = 1'b0; READ = 1'b0;
    ADDR_W = '0; DATA_W = '0; ADDR_R1 = '0; ADDR_R2 = '0;
  endtask

  task automatic test_reset();
    idle();
    RST = 1'b1;
    tick();
    tick();
    checks++;
    if ({a_r1, a_r2, a_rv, a_ae} !== 66'd0) begin
      failures++;
      $display("FAIL reset_outputs got r1=%h r2=%h rv=%b ae=%b required all 0", a_r1, a_r2, a_rv, a_ae);
    end
    RST = 1'b0; READ = 1'b1; ADDR_R1 = 5'd5; ADDR_R2 = 5'd31;
    tick();
    checks++;
    if (a_r1 !== 32'd0 || a_r2 !== 32'd0 || a_rv !== 1'b1 || a_ae !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_read got r1=%h r2=%h rv=%b ae=%b required 0 0 1 0", a_r1, a_r2, a_rv, a_ae);
    end
    checks++;
    if (c_ae !== 1'b1 || c_r2 !== 32'd0) begin
      failures++;
      $display("FAIL reset_read_oor_d24 got ae=%b r2=%h required ae=1 r2=0", c_ae, c_r2);
    end
    idle();
  endtask

  task automatic test_sweep();
    logic [31:0] e1, e2;
    for (int k = 0; k < 32; k++) begin
      idle();
      WRITE = 1'b1; ADDR_W = 5'(k); DATA_W = 32'(k + 100);
      tick();
    end
    for (int k = 0; k < 32; k++) begin
      idle();
      READ = 1'b1; ADDR_R1 = 5'(k); ADDR_R2 = 5'(31 - k);
      tick();
      e1 = (k == 0)  ? 32'd0 : 32'(k + 100);
      e2 = (k == 31) ? 32'd0 : 32'(131 - k);
      checks++;
      if (a_r1 !== e1 || a_r2 !== e2 || a_rv !== 1'b1) begin
        failures++;
        $display("FAIL sweep k=%0d got r1=%h r2=%h rv=%b required r1=%h r2=%h rv=1", k, a_r1, a_r2, a_rv, e1, e2);
      end
      checks++;
      if (b_r1 !== 32'(k + 100) || b_r2 !== 32'(131 - k)) begin
        failures++;
        $display("FAIL sweep_nozero k=%0d got r1=%h r2=%h required r1=%h r2=%h", k, b_r1, b_r2, 32'(k + 100), 32'(131 - k));
      end
    end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    WRITE = 1'b1; ADDR_W = 5'd7; DATA_W = 32'h11;
    tick();
    WRITE = 1'b1; ADDR_W = 5'd7; DATA_W = 32'hABCD;
    READ = 1'b1; ADDR_R1 = 5'd7; ADDR_R2 = 5'd7;
    tick();
    checks++;
    if (a_r1 !== 32'hABCD || a_r2 !== 32'hABCD) begin
      failures++;
      $display("FAIL bypass_on got r1=%h r2=%h required abcd abcd", a_r1, a_r2);
    end
    checks++;
    if (b_r1 !== 32'h11 || b_r2 !== 32'h11) begin
      failures++;
      $display("FAIL bypass_off_old got r1=%h r2=%h required 11 11", b_r1, b_r2);
    end
    idle();
    READ = 1'b1; ADDR_R1 = 5'd7; ADDR_R2 = 5'd8;
    tick();
    checks++;
    if (b_r1 !== 32'hABCD || b_r2 !== 32'd108) begin
      failures++;
      $display("FAIL bypass_off_next got r1=%h r2=%h required abcd 6c", b_r1, b_r2);
    end
    idle();
  endtask

  task automatic test_zero();
    idle();
    WRITE = 1'b1; ADDR_W = 5'd0; DATA_W = 32'hFFFF_FFFF;
    READ = 1'b1; ADDR_R1 = 5'd0; ADDR_R2 = 5'd1;
    tick();
    checks++;
    if (a_r1 !== 32'd0 || b_r1 !== 32'd100 || a_r2 !== 32'd101) begin
      failures++;
      $display("FAIL zero_same_cycle got a_r1=%h b_r1=%h a_r2=%h required 0 64 65", a_r1, b_r1, a_r2);
    end
    idle();
    READ = 1'b1; ADDR_R1 = 5'd0; ADDR_R2 = 5'd0;
    tick();
    checks++;
    if (a_r1 !== 32'd0 || a_r2 !== 32'd0) begin
      failures++;
      $display("FAIL zero_reg got r1=%h r2=%h required 0 0", a_r1, a_r2);
    end
    checks++;
    if (b_r1 !== 32'hFFFF_FFFF || b_r2 !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL zero_disabled got r1=%h r2=%h required ffffffff ffffffff", b_r1, b_r2);
    end
    idle();
  endtask

  task automatic test_out_of_range();
    idle();
    WRITE = 1'b1; ADDR_W = 5'd25; DATA_W = 32'hDEAD;
    tick();
    checks++;
    if (c_ae !== 1'b1 || a_ae !== 1'b0) begin
      failures++;
      $display("FAIL oor_write_err got d24=%b d32=%b required 1 0", c_ae, a_ae);
    end
    idle();
    READ = 1'b1; ADDR_R1 = 5'd30; ADDR_R2 = 5'd23;
    tick();
    checks++;
    if (c_r1 !== 32'd0 || c_r2 !== 32'd123 || c_ae !== 1'b1) begin
      failures++;
      $display("FAIL oor_read_r1 got r1=%h r2=%h ae=%b required 0 7b 1", c_r1, c_r2, c_ae);
    end
    idle();
    READ = 1'b1; ADDR_R1 = 5'd3; ADDR_R2 = 5'd24;
    tick();
    checks++;
    if (c_r1 !== 32'd103 || c_r2 !== 32'd0 || c_ae !== 1'b1) begin
      failures++;
      $display("FAIL oor_read_r2 got r1=%h r2=%h ae=%b required 67 0 1", c_r1, c_r2, c_ae);
    end
    idle();
    READ = 1'b1; ADDR_R1 = 5'd2; ADDR_R2 = 5'd1;
    tick();
    checks++;
    if (c_ae !== 1'b0 || c_r1 !== 32'd102 || c_r2 !== 32'd101) begin
      failures++;
      $display("FAIL oor_clear got ae=%b r1=%h r2=%h required 0 66 65", c_ae, c_r1, c_r2);
    end
    idle();
  endtask

  task automatic test_hold();
    idle();
    WRITE = 1'b1; ADDR_W = 5'd4; DATA_W = 32'h55;
    tick();
    idle();
    READ = 1'b1; ADDR_R1 = 5'd4;
    tick();
    checks++;
    if (a_r1 !== 32'h55 || a_rv !== 1'b1) begin
      failures++;
      $display("FAIL hold_setup got r1=%h rv=%b required 55 1", a_r1, a_rv);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      ADDR_R1 = 5'd30; ADDR_R2 = 5'd9;
      tick();
      checks++;
      if (a_r1 !== 32'h55 || a_rv !== 1'b0 || c_ae !== 1'b0) begin
        failures++;
        $display("FAIL hold cyc=%0d got r1=%h rv=%b ae=%b required 55 0 0", i, a_r1, a_rv, c_ae);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    idle();
    WRITE = 1'b1; ADDR_W = 5'd5; DATA_W = 32'h77;
    tick();
    WRITE = 1'b1; ADDR_W = 5'd6; DATA_W = 32'h88;
    READ = 1'b1; ADDR_R1 = 5'd5; ADDR_R2 = 5'd6;
    tick();
    checks++;
    if (b_r1 !== 32'h77 || b_r2 !== 32'd106 || a_r2 !== 32'h88) begin
      failures++;
      $display("FAIL back_to_back got b_r1=%h b_r2=%h a_r2=%h required 77 6a 88", b_r1, b_r2, a_r2);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    idle();
    RST = 1'b1; WRITE = 1'b1; ADDR_W = 5'd3; DATA_W = 32'd9;
    READ = 1'b1; ADDR_R1 = 5'd3;
    tick();
    checks++;
    if (a_rv !== 1'b0 || a_r1 !== 32'd0 || a_r2 !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset_out got rv=%b r1=%h r2=%h required 0 0 0", a_rv, a_r1, a_r2);
    end
    idle();
    READ = 1'b1; ADDR_R1 = 5'd3; ADDR_R2 = 5'd4;
    tick();
    checks++;
    if (a_r1 !== 32'd0 || a_r2 !== 32'd0 || b_r1 !== 32'd0 || a_rv !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_mem got a_r1=%h a_r2=%h b_r1=%h rv=%b required 0 0 0 1", a_r1, a_r2, b_r1, a_rv);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_sweep();
    test_bypass();
    test_zero();
    test_out_of_range();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_nxw.md
# reg_file_nxw

Parametrised multi-port register file for the processor datapath: DEPTH words of WIDTH bits, one synchronous write port and two independent read ports. Each read port uses a DEPTH-to-1 word select with a registered output, and a qualifying read flag. Optional behaviours are zero-register and write-to-read bypass. It supersedes the fixed 32-word, 32-bit, purely combinational register select.

## Interface
- WIDTH, 32, data word width in bits (>=1)
- DEPTH, 32, number of words (2..2^AW)
- AW, 5, address width; addresses >= DEPTH are out of range
- ZERO_REG, 1, 1 = word 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to a matching read

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- WRITE  in  1  write enable
- ADDR_W  in  AW  write address
- DATA_W  in  WIDTH  write data
- READ  in  1  read enable, both ports
- ADDR_R1  in  AW  read port 1 address
- ADDR_R2  in  AW  read port 2 address
- DATA_R1  out  WIDTH  registered read data, port 1
- DATA_R2  out  WIDTH  registered read data, port 2
- R_VALID  out  1  DATA_R1/DATA_R2 updated by the previous cycle's READ
- ADDR_ERR  out  1  previous cycle had an enabled access out of range

## Operation
- Write is valid when WRITE=1, ADDR_W < DEPTH, and not (ZERO_REG=1 and ADDR_W=0). A valid write sets mem[ADDR_W] <= DATA_W at the edge. An invalid write leaves all words unchanged.
- Read select for port n:
  - If ADDR_Rn >= DEPTH, the result is 0.
  - Else if ZERO_REG=1 and ADDR_Rn=0, the result is 0.
  - Else if BYPASS=1, the write is valid, and ADDR_W=ADDR_Rn, the result is DATA_W.
  - Otherwise the result is mem[ADDR_Rn] as it was before the edge.
- READ=1: DATA_Rn <= select result; R_VALID <= 1.
- READ=0: DATA_R1 and DATA_R2 hold their values; R_VALID <= 0.
- ADDR_ERR <= 1 when (WRITE and ADDR_W >= DEPTH) or (READ and either ADDR_Rn >= DEPTH). Otherwise ADDR_ERR <= 0. The flag is not sticky.
- Both ports may address the same word; both return the same value.
- With BYPASS=0, a read of the word being written returns the old value.

## Timing
- Read latency is 1 cycle: address and READ are sampled at edge k, and data/R_VALID are visible after edge k.
- Write latency is 1 cycle: the word is written at edge k. A non-bypassed read sampled at edge k+1 returns the new value.
- RST=1 at an edge has priority over WRITE and READ. At that edge:
  - all DEPTH words are set to 0;
  - DATA_R1 and DATA_R2 are set to 0;
  - R_VALID and ADDR_ERR are set to 0.
- Reset asserted mid-sequence discards the write and read requested in that cycle. The first access honoured is the one sampled at the first edge with RST=0.
- No combinational path from inputs to outputs. All outputs are registered.
- Reset values: DATA_R1=0, DATA_R2=0, R_VALID=0, ADDR_ERR=0, all memory words 0.

## Test plan
- Reset then read: defaults, RST=1 for 2 cycles, then READ=1 with ADDR_R1=5, ADDR_R2=31 -> DATA_R1=0, DATA_R2=0, R_VALID=1 one cycle later.
- Write/read sweep: write k+100 to every address k=0..31, then read pairs (k, 31-k) -> DATA_R1=k+100 and DATA_R2=131-k, except address 0 reads 0. Checks all 32 select positions.
- Bypass: mem[7]=0x11. In one cycle, WRITE=1, ADDR_W=7, DATA_W=0xABCD, READ=1, ADDR_R1=7 -> DATA_R1=0xABCD. Repeat with BYPASS=0 -> DATA_R1=0x11, and the next read gives 0xABCD.
- Zero register: write 0xFFFFFFFF to address 0 -> a read of address 0 returns 0. With ZERO_REG=0 the same read returns 0xFFFFFFFF.
- Out of range, DEPTH=24, AW=5:
  - WRITE to address 25 -> ADDR_ERR=1 next cycle, memory unchanged.
  - READ of address 30 -> DATA_R1=0, ADDR_ERR=1.
  - A following in-range access -> ADDR_ERR=0.
- Hold and mid-reset:
  - READ=0 for 3 cycles after a read of 0x55 -> DATA_R1 stays 0x55 and R_VALID=0.
  - RST=1 coincident with WRITE of 9 to address 3 -> the next read of address 3 returns 0.
